// File: rtl/sum_to_bcd_pkg.sv
// Shared sizing and FSM encoding for the adder-sum to BCD display path.
// SUM_WIDTH tracks the adder output width; BCD_DIGITS covers its full decimal range.
package sum_to_bcd_pkg;

  localparam int SUM_WIDTH  = 18;
  localparam int BCD_DIGITS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sum_to_bcd_if.sv
// Start/busy/done handshake between the control FSM (master) and the converter (slave).
// No backpressure: the converter drops start while busy, and it does not queue requests.
interface sum_to_bcd_if
  import sum_to_bcd_pkg::*;
#(
  parameter int WIDTH  = SUM_WIDTH,
  parameter int DIGITS = BCD_DIGITS
);

  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);

endinterface

// File: rtl/sum_to_bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more, zero latency.
// Purely combinational, so it has no backpressure. Inputs are always <=9, so the sum fits in 4 bits.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) adjusted = digit + 4'd3;
  end

endmodule

// File: rtl/sum_to_bcd.sv
// Iterative binary-to-BCD converter. It handles one bit per clock, and done follows acceptance by WIDTH clocks.
// No backpressure: start is sampled only in IDLE. bcd holds the last result until the next done.
module sum_to_bcd
  import sum_to_bcd_pkg::*;
#(
  parameter int WIDTH  = SUM_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic          clk,
  input  logic          reset,
  sum_to_bcd_if.slave   bus
);

  localparam int SR_W = 4*DIGITS + WIDTH;
  localparam int CW   = $clog2(WIDTH + 1);

  state_t              state;
  logic [SR_W-1:0]     sreg;
  logic [CW-1:0]       cnt;
  logic                busy_q;
  logic                done_q;
  logic [4*DIGITS-1:0] bcd_q;

  logic [4*DIGITS-1:0] adj_digits;
  logic [SR_W-1:0]     shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (sreg[WIDTH + 4*g +: 4]),
      .adjusted (adj_digits[4*g +: 4])
    );
  end

  assign shifted = {adj_digits, sreg[WIDTH-1:0]} << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sreg   <= {{(4*DIGITS){1'b0}}, bus.bin};
            cnt    <= CW'(WIDTH);
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= shifted;
          cnt  <= cnt - 1'b1;
          // The final step's result goes straight to bcd so that no partial value is ever visible.
          if (cnt == CW'(1)) begin
            bcd_q  <= shifted[SR_W-1 -: 4*DIGITS];
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: doc/sum_to_bcd.md
Name: sum_to_bcd

Overview:
- Sequential binary-to-BCD converter that sits directly downstream of the 17-bit adder.
- Captures the adder's 18-bit unsigned sum and converts it to six packed BCD digits for the 7-segment HEX display drivers.
- Uses the iterative shift-add-3 (double-dabble) algorithm: one bit per clock, so area stays small.
- Exposes a start/busy/done handshake to the control FSM.

Parameters:
- WIDTH, 18, width of the binary input (adder sum width).
- DIGITS, 6, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value (adder sum); captured on the accepted start edge.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result valid on bcd.
- bcd  output  4*DIGITS  packed BCD result; digit 0 in bcd[3:0]; held until the next done.

Behaviour:
- Reset (synchronous, active-high, dominates all inputs):
  - state=IDLE; busy=0; done=0; bcd=0.
  - Internal shift register and counter are cleared.
- States: IDLE, SHIFT, DONE (localparam encoding).
- IDLE:
  - On a clock edge with start=1: load bin into the low WIDTH bits of the shift register, clear the BCD field, set counter=WIDTH, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT: each cycle performs one step.
  - (a) Every BCD digit >=5 gets +3 (combinational, all digits in parallel).
  - (b) The whole {bcd_field, bin_field} register shifts left by 1.
  - (c) counter decrements.
  - When counter reaches 1 on this edge (last step), go to DONE, register the final BCD field onto bcd, and set done=1.
- DONE:
  - done=1 for exactly this one cycle; busy stays 1.
  - Next edge: go to IDLE, done=0.
- Latency:
  - start accepted at edge k; shift steps occur on edges k+1..k+WIDTH.
  - done is high in the cycle following edge k+WIDTH (18 clocks after acceptance).
  - busy is high from edge k through edge k+WIDTH+1.
  - Earliest next acceptance is edge k+WIDTH+2.
- Handshake rules:
  - start while busy (SHIFT or DONE): ignored, not queued.
  - start held continuously high: a new conversion begins on the first IDLE edge, giving back-to-back throughput of one result per WIDTH+2 cycles.
  - bin changing after acceptance has no effect on the current result.
- Output rules:
  - bcd changes only on the DONE-entry edge or on reset.
  - bcd never shows intermediate values.
- Arithmetic:
  - Shift register is 4*DIGITS+WIDTH bits.
  - Counter width is clog2(WIDTH+1).
  - Add-3 is 4-bit and never overflows, because digits are <=9 before adjustment.
  - Full range 0..2^WIDTH-1 must convert exactly; there is no saturation.
- Reset mid-operation:
  - Conversion is aborted; go to IDLE with outputs as in reset.
  - No done pulse occurs for the aborted request.
  - The first start after reset deasserts is accepted normally.
- start and reset asserted on the same edge: reset wins; start is not accepted.

Decomposition:
- Shared constants include file holds:
  - SUM_WIDTH=18 (shared with the adder output width).
  - BCD_DIGITS=6.
  - State encodings IDLE/SHIFT/DONE.
- Sub-module bcd_digit_adjust:
  - Combinational 4-bit digit in, digit+3 out if >=5, else passthrough.
  - Instantiated DIGITS times via generate.
- Top holds the FSM, counter, shift register, and output register.

Test Plan:
- Reset then idle 5 cycles -> busy=0, done=0, bcd=24'h000000 throughout.
- bin=0, start 1 cycle -> done pulses exactly 18 clocks after acceptance, bcd=24'h000000, busy falls the cycle after done.
- bin=262143 (18'h3FFFF) -> bcd=24'h262143; also bin=262142 (max 17+17-bit sum) -> 24'h262142.
- Digit boundaries back-to-back with start held high:
  - bin=9 -> 24'h000009.
  - bin=10 -> 24'h000010.
  - bin=99999 -> 24'h099999.
  - bin=100000 -> 24'h100000.
  - Each done is spaced exactly 20 cycles apart.
- bin=12345 start, then bin=54321 with start pulsed at cycle 5 of the conversion -> single done with bcd=24'h012345; second request not executed.
- bin=77777 start, reset asserted for 1 cycle at the 10th SHIFT cycle -> no done pulse, bcd=0, busy=0; following start with bin=500 -> bcd=24'h000500.
